// File: rtl/demux1_4_buf_pkg.sv
// Shared definitions for the buffered 1-to-4 byte demultiplexer.
// Provides the default data width, the channel count, the destination select
// encodings and the select decoder used to build the per-channel push vector.
package demux1_4_buf_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned NumChan      = 4;

  typedef enum logic [1:0] {
    CH0 = 2'b00,
    CH1 = 2'b01,
    CH2 = 2'b10,
    CH3 = 2'b11
  } chan_sel_e;

  // One-hot target vector for a request; broadcast targets every channel.
  function automatic logic [NumChan-1:0] sel_decode(input logic [1:0] sel, input logic bcast);
    logic [NumChan-1:0] onehot;
    onehot = '0;
    if (bcast) begin
      onehot = '1;
    end else begin
      unique case (chan_sel_e'(sel))
        CH0: onehot = 4'b0001;
        CH1: onehot = 4'b0010;
        CH2: onehot = 4'b0100;
        CH3: onehot = 4'b1000;
        default: onehot = '0;
      endcase
    end
    return onehot;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-destination FIFO for demux1_4_buf.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (clears storage, ptrs, count)
//   push, din     write request and data; ignored while full
//   pop           read request; ignored while empty
//   dout          raw head entry (caller masks it when empty)
//   count         current occupancy 0..DEPTH
//   full, empty   occupancy flags derived from the registered count
module demux_chan_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when it pops on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/demux1_4_buf.sv
// Buffered 1-to-4 demultiplexer.
// A producer offers d with a destination select s (or bcast for all four);
// each byte lands in a small per-channel FIFO that its consumer drains via
// v[k]/rdy[k].
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   d, s, bcast         request data, destination select, broadcast flag
//   in_valid, in_ready  producer handshake; in_ready depends only on stored counts
//   y0..y3              head-of-FIFO data per channel, zero when that channel is empty
//   v                   per-channel non-empty flags
//   rdy                 per-channel consumer ready
module demux1_4_buf
  import demux1_4_buf_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  input  logic             bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       v,
  input  logic [3:0]       rdy
);

  logic [NumChan-1:0] target;
  logic [NumChan-1:0] push;
  logic [NumChan-1:0] pop;
  logic [NumChan-1:0] full;
  logic [NumChan-1:0] empty;
  logic [WIDTH-1:0]   dout  [NumChan];
  logic [WIDTH-1:0]   y_arr [NumChan];
  logic [CntW-1:0]    count [NumChan];
  logic               accept;

  assign target = sel_decode(s, bcast);

  // Built from registered occupancy only, so rdy never reaches in_ready.
  always_comb begin
    in_ready = 1'b0;
    if (bcast) begin
      in_ready = ~|full;
    end else begin
      in_ready = ~full[s];
    end
  end

  assign accept = in_valid & in_ready;
  assign push   = target & {NumChan{accept}};
  assign pop    = v & rdy;

  for (genvar k = 0; k < NumChan; k++) begin : g_chan
    demux_chan_fifo #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[k]),
      .din  (d),
      .pop  (pop[k]),
      .dout (dout[k]),
      .count(count[k]),
      .full (full[k]),
      .empty(empty[k])
    );

    assign v[k]     = (count[k] != '0);
    assign y_arr[k] = empty[k] ? '0 : dout[k];
  end

  assign y0 = y_arr[0];
  assign y1 = y_arr[1];
  assign y2 = y_arr[2];
  assign y3 = y_arr[3];

endmodule

// File: tb/tb_demux1_4_buf.sv
`timescale 1ns/1ps
module tb_demux1_4_buf;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] d = '0;
  logic [1:0]   s = '0;
  logic         bcast = 1'b0;
  logic         in_valid = 1'b0;
  logic [3:0]   rdy = '0;
  logic         in_ready;
  logic [W-1:0] y0, y1, y2, y3;
  logic [3:0]   v;

  int errors = 0;
  int checks = 0;

  // Reference: one plain queue of bytes per channel.
  logic [W-1:0] mq [4][$];
  logic [W-1:0] wrap_log [$];
  bit           log_en = 1'b0;

  demux1_4_buf #(
    .WIDTH(W),
    .DEPTH(2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .s       (s),
    .bcast   (bcast),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y0      (y0),
    .y1      (y1),
    .y2      (y2),
    .y3      (y3),
    .v       (v),
    .rdy     (rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    if (bcast) begin
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() >= 2) return 1'b0;
      end
      return 1'b1;
    end
    return mq[s].size() < 2;
  endfunction

  function automatic logic [W-1:0] exp_y(input int k);
    return (mq[k].size() != 0) ? mq[k][0] : '0;
  endfunction

  function automatic logic [W-1:0] y_of(input int k);
    case (k)
      0:       return y0;
      1:       return y1;
      2:       return y2;
      default: return y3;
    endcase
  endfunction

  // Model update: the accept decision uses occupancy before this edge's pops.
  always @(posedge clk) begin
    bit acc;
    if (!rst) begin
      acc = in_valid && model_ready();
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() != 0 && rdy[k]) void'(mq[k].pop_front());
      end
      if (acc) begin
        for (int k = 0; k < 4; k++) begin
          if (bcast || int'(s) == k) mq[k].push_back(d);
        end
      end
    end
  end

  always @(posedge rst) begin
    for (int k = 0; k < 4; k++) mq[k].delete();
  end

  always @(posedge clk) begin
    if (log_en && !rst && v[1] && rdy[1]) wrap_log.push_back(y1);
  end

  // Every-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] ev;
    for (int k = 0; k < 4; k++) ev[k] = (mq[k].size() != 0);
    check("v", {28'd0, v}, {28'd0, ev});
    check("y0", {24'd0, y0}, {24'd0, exp_y(0)});
    check("y1", {24'd0, y1}, {24'd0, exp_y(1)});
    check("y2", {24'd0, y2}, {24'd0, exp_y(2)});
    check("y3", {24'd0, y3}, {24'd0, exp_y(3)});
    check("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] dd, input logic [1:0] ss, input logic bc);
    d        = dd;
    s        = ss;
    bcast    = bc;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    bcast    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int  i;
    int  n;
    bit  acc;

    rst = 1'b1;
    repeat (2) cyc();
    check("rst_v", {28'd0, v}, 32'h0);
    check("rst_in_ready", {31'd0, in_ready}, 32'h1);
    rst = 1'b0;

    // Async reset mid-operation discards ch2 contents.
    rdy = 4'b0000;
    send(8'h11, 2'd2, 1'b0); cyc();
    send(8'h22, 2'd2, 1'b0); cyc();
    idle();
    check("fill_v", {28'd0, v}, 32'h4);
    check("fill_y2", {24'd0, y2}, 32'h11);
    #2 rst = 1'b1;
    #1;
    check("arst_v", {28'd0, v}, 32'h0);
    check("arst_y2", {24'd0, y2}, 32'h0);
    check("arst_in_ready", {31'd0, in_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'h33, 2'd2, 1'b0); cyc();
    idle();
    check("post_rst_y2", {24'd0, y2}, 32'h33);
    rdy = 4'b0100; cyc();
    check("post_rst_drain_v", {28'd0, v}, 32'h0);

    // Steering with all consumers ready.
    rdy = 4'hF;
    for (int k = 0; k < 4; k++) begin
      send(8'(8'hA0 + k), 2'(k), 1'b0);
      cyc();
      check("steer_v", {28'd0, v}, 32'(1 << k));
      check("steer_y", {24'd0, y_of(k)}, 32'(8'hA0 + k));
    end
    idle(); cyc();
    check("steer_end_v", {28'd0, v}, 32'h0);

    // Back-pressure on ch1, including a refused push on a full, popping channel.
    rdy = 4'b1101;
    send(8'h55, 2'd1, 1'b0); cyc();
    send(8'h66, 2'd1, 1'b0); cyc();
    send(8'h77, 2'd1, 1'b0); #1;
    check("full_in_ready", {31'd0, in_ready}, 32'h0);
    cyc();
    check("full_hold_y1", {24'd0, y1}, 32'h55);
    send(8'h99, 2'd0, 1'b0); #1;
    check("other_in_ready", {31'd0, in_ready}, 32'h1);
    cyc();
    check("other_y0", {24'd0, y0}, 32'h99);
    rdy = 4'hF;
    send(8'h77, 2'd1, 1'b0); #1;
    check("pushpop_in_ready", {31'd0, in_ready}, 32'h0);
    cyc();
    check("pushpop_y1", {24'd0, y1}, 32'h66);
    check("pushpop_after_ready", {31'd0, in_ready}, 32'h1);
    cyc();
    check("late_y1", {24'd0, y1}, 32'h77);
    idle(); cyc();
    check("bp_end_v", {28'd0, v}, 32'h0);

    // Broadcast.
    rdy = 4'h0;
    send(8'hC3, 2'd1, 1'b1); cyc();
    check("bc_v", {28'd0, v}, 32'hF);
    for (int k = 0; k < 4; k++) check("bc_y", {24'd0, y_of(k)}, 32'hC3);
    send(8'h5A, 2'd0, 1'b0); cyc();
    send(8'hEE, 2'd2, 1'b1); #1;
    check("bc_blocked", {31'd0, in_ready}, 32'h0);
    cyc();
    check("bc_blocked_y0", {24'd0, y0}, 32'hC3);
    rdy = 4'b0001; #1;
    check("bc_no_rdy_path", {31'd0, in_ready}, 32'h0);
    cyc();
    check("bc_freed", {31'd0, in_ready}, 32'h1);
    check("bc_freed_y0", {24'd0, y0}, 32'h5A);
    rdy = 4'h0; cyc();
    check("bc_accept_v", {28'd0, v}, 32'hF);
    idle(); rdy = 4'hF;
    repeat (3) cyc();
    check("bc_end_v", {28'd0, v}, 32'h0);

    // Wrap-around through ch1 with a toggling consumer.
    rdy    = 4'h0;
    log_en = 1'b1;
    i = 1;
    n = 0;
    while (i <= 10 && n < 200) begin
      send(8'(i), 2'd1, 1'b0);
      rdy[1] = n[0];
      #1 acc = in_ready;
      cyc();
      if (acc) i++;
      n++;
    end
    idle(); rdy[1] = 1'b1;
    repeat (4) cyc();
    log_en = 1'b0;
    check("wrap_sent", 32'(i), 32'd11);
    check("wrap_count", 32'(wrap_log.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < wrap_log.size()) check("wrap_order", {24'd0, wrap_log[k]}, 32'(k + 1));
    end

    // Randomised traffic with occasional asynchronous resets.
    repeat (3000) begin
      d        = 8'($urandom);
      s        = 2'($urandom);
      bcast    = ($urandom_range(0, 7) == 0);
      in_valid = 1'($urandom);
      rdy      = 4'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1;
        check("rand_arst_v", {28'd0, v}, 32'h0);
        check("rand_arst_in_ready", {31'd0, in_ready}, 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
      end else begin
        cyc();
      end
    end
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux1_4_buf.md
# demux1_4_buf

Buffered 1-to-4 demultiplexer for 8-bit data: the distribution counterpart of the datapath's 4:1 select muxes. A single producer presents a byte with a 2-bit destination select (or a broadcast flag). The block steers the byte into one of four per-destination 2-entry FIFOs, or into all four. Each destination drains its FIFO independently through a valid/ready handshake, which decouples one source from four consumers with independent back-pressure.

## Interface
- WIDTH, 8, data width of every channel
- DEPTH, 2, entries per destination FIFO (fixed at 2; a parameter only for future widening)
- clk  in  1  single clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- d  in  WIDTH  input data
- s  in  2  destination select (00→ch0 … 11→ch3); ignored when bcast=1
- bcast  in  1  broadcast: write d to all four channels
- in_valid  in  1  producer offers d
- in_ready  out  1  block can accept the current request
- y0, y1, y2, y3  out  WIDTH  head-of-FIFO data per channel
- v  out  4  per-channel output valid (bit k = channel k non-empty)
- rdy  in  4  per-channel consumer ready

## Operation
- Per-channel state: 2 storage regs, 1-bit write ptr, 1-bit read ptr, 2-bit count (0..2).
- Write targets: bcast=0 → channel s only; bcast=1 → all four.
- in_ready (combinational, from registered counts only; no path from rdy):
  - bcast=0 → count[s] < 2.
  - bcast=1 → all four counts < 2.
- Accept = in_valid & in_ready; on accept, each target stores d at its write ptr and increments the ptr (wraps 1→0).
- Pop on channel k = v[k] & rdy[k]; the read ptr increments (wraps).
- count_k next = count_k + push_k − pop_k; push and pop on the same edge leave count unchanged.
- A full channel (count=2) refuses a push even if it pops in the same cycle. The decision is deterministic and has no ready-through path.
- v[k] = (count_k != 0). y_k = storage[read ptr] when v[k]=1, else 0.
- in_valid=0: no state change except pops. s and bcast matter only on accept.
- Order preserved per channel: FIFO, including bytes delivered by broadcast.
- Reset (async, any time, including mid-transfer): all counts and ptrs = 0, storage = 0. Pending data is discarded. Outputs: v=0, y0..y3=0, in_ready=1. Inputs are ignored while rst=1.

## Timing
- Latency: a byte accepted at edge N appears on y_s with v[s]=1 right after edge N (visible in cycle N+1). No combinational d→y path.
- Throughput: 1 byte/cycle into any channel whose consumer drains every cycle. A stalled channel blocks only requests addressed to it or broadcasts.
- Pop: the handshake completes at an edge where v[k]&rdy[k]=1. The next entry, or 0 if empty, shows after that edge.
- in_ready can change in the cycle after a pop frees space, never within the same cycle.
- Reset release: the first accept is possible at the first rising edge with rst=0.

## Structure
- Shared package/include: WIDTH default, channel count (4), channel-select encodings (CH0..CH3).
- Sub-module demux_chan_fifo (WIDTH, 2-entry FIFO: push, din, pop, dout, count/full/empty), instantiated 4×.
- Top: select decode (one-hot push vector, all-ones on bcast), in_ready logic, y zero-masking.

## Test plan
- Reset mid-operation: fill ch2 with 0x11, 0x22, assert rst asynchronously between edges → v=0000, y2=0x00, in_ready=1 immediately. After release, ch2 delivers only new data.
- Steering: rdy=1111; send 0xA0/s=00, 0xA1/s=01, 0xA2/s=10, 0xA3/s=11 on consecutive cycles → each y_k=0xAk with v[k]=1 for exactly one cycle, one cycle after its accept.
- Full/back-pressure: rdy[1]=0; send 0x55, 0x66, 0x77 to s=01 → first two accepted, in_ready=0 on the third. Sends to s=00 are still accepted. Raise rdy[1] → y1 gives 0x55 then 0x66, then 0x77 is accepted.
- Same-cycle push/pop on full: ch3 full, rdy[3]=1, in_valid with s=11 → push refused that cycle and count drops to 1. The push is accepted on the next cycle.
- Broadcast: rdy=0000, send 0xC3 with bcast=1 → v=1111, all y=0xC3. Fill ch0 with a second byte, then a broadcast request → in_ready=0 until ch0 pops.
- Wrap-around: 10 sequential bytes 0x01..0x0A through ch1 with rdy[1] toggling 1/0 → output order exact, no loss or duplication across ptr wraps.
